// File: rtl/pong_sequencer.sv
// Game-flow sequencer for a VGA pong: serve hold, play, miss flash and game over.
// Owns score (BCD), lives and speed level; the datapath owns ball motion.
module pong_sequencer #(
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 63,
    parameter int SPEEDUP_HITS = 5
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic       go,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_reset,
    output logic       ball_run,
    output logic       flash,
    output logic       game_over,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [1:0] speed,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_LOAD  = 8'(MISS_FRAMES - 1);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [3:0] HIT_LAST   = 4'(SPEEDUP_HITS - 1);

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic [1:0] speed_q, speed_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] hit_cnt_q, hit_cnt_d;
    logic       ball_reset_q, ball_reset_d;
    logic       ball_run_q, ball_run_d;
    logic       flash_q, flash_d;
    logic       game_over_q, game_over_d;
    logic       go_s1_q, go_s1_d, go_s2_q, go_s2_d, go_s3_q, go_s3_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;
    logic       frame_tick, go_edge;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        frame_tick = (xpos == 10'd0) && (ypos == 10'd480);
        go_s1_d    = go;
        go_s2_d    = go_s1_q;
        go_s3_d    = go_s2_q;
        // Edges are accepted only once go has been seen low after reset, so a
        // button held through reset release cannot start a game.
        fill_d     = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d    = armed_q | ((fill_q == 2'd2) && !go_s2_q);
        go_edge    = go_s2_q & ~go_s3_q & armed_q;

        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        speed_d      = speed_q;
        frame_cnt_d  = frame_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        ball_reset_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (go_edge) begin
                    state_d      = S_SERVE;
                    score_d      = 8'h00;
                    lives_d      = LIVES_LOAD;
                    speed_d      = 2'd0;
                    hit_cnt_d    = 4'd0;
                    frame_cnt_d  = SERVE_LOAD;
                    ball_reset_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q == 8'd0)
                        state_d = S_PLAY;
                    else
                        frame_cnt_d = frame_cnt_q - 8'd1;
                end
            end
            S_PLAY: begin
                // A simultaneous hit is discarded: the ball is already lost.
                if (miss) begin
                    state_d     = S_MISS;
                    lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    frame_cnt_d = MISS_LOAD;
                end else if (hit) begin
                    score_d = bcd_inc(score_q);
                    if (hit_cnt_q == HIT_LAST) begin
                        hit_cnt_d = 4'd0;
                        speed_d   = (speed_q == 2'd3) ? 2'd3 : speed_q + 2'd1;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 4'd1;
                    end
                end
            end
            S_MISS: begin
                if (frame_tick) begin
                    if (frame_cnt_q != 8'd0) begin
                        frame_cnt_d = frame_cnt_q - 8'd1;
                    end else if (lives_q == 2'd0) begin
                        state_d = S_OVER;
                    end else begin
                        state_d      = S_SERVE;
                        frame_cnt_d  = SERVE_LOAD;
                        ball_reset_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ball_run_d  = (state_d == S_PLAY);
        flash_d     = (state_d == S_MISS);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q      <= S_IDLE;
            score_q      <= 8'h00;
            lives_q      <= LIVES_LOAD;
            speed_q      <= 2'd0;
            frame_cnt_q  <= 8'd0;
            hit_cnt_q    <= 4'd0;
            ball_reset_q <= 1'b0;
            ball_run_q   <= 1'b0;
            flash_q      <= 1'b0;
            game_over_q  <= 1'b0;
            go_s1_q      <= 1'b0;
            go_s2_q      <= 1'b0;
            go_s3_q      <= 1'b0;
            fill_q       <= 2'd0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            speed_q      <= speed_d;
            frame_cnt_q  <= frame_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            ball_reset_q <= ball_reset_d;
            ball_run_q   <= ball_run_d;
            flash_q      <= flash_d;
            game_over_q  <= game_over_d;
            go_s1_q      <= go_s1_d;
            go_s2_q      <= go_s2_d;
            go_s3_q      <= go_s3_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
        end
    end

    assign ball_reset = ball_reset_q;
    assign ball_run   = ball_run_q;
    assign flash      = flash_q;
    assign game_over  = game_over_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign speed      = speed_q;
    assign state      = state_q;

endmodule

// File: doc/pong_sequencer.md
PONG_SEQUENCER -- requirements
Module: pong_sequencer

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives at game start (1..3).
REQ-002 Parameter SERVE_FRAMES, default 60, frames ball is held before each serve (1..255).
REQ-003 Parameter MISS_FRAMES, default 63, frames of miss-flash after a miss (1..255).
REQ-004 Parameter SPEEDUP_HITS, default 5, paddle hits per speed-level increment (1..15).
REQ-005 clk25  input  1  25 MHz pixel clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 xpos  input  10  current scan column from VGA timing.
REQ-008 ypos  input  10  current scan row from VGA timing.
REQ-009 go  input  1  start button; asynchronous, level.
REQ-010 hit  input  1  one-cycle pulse from datapath on paddle/ball contact.
REQ-011 miss  input  1  one-cycle pulse from datapath when ball reaches bottom border.
REQ-012 ball_reset  output  1  one-cycle pulse: datapath recentres ball and resets directions.
REQ-013 ball_run  output  1  level; datapath moves ball at frame end only while high.
REQ-014 flash  output  1  level; high during miss-flash.
REQ-015 game_over  output  1  level; high in OVER.
REQ-016 score  output  8  two BCD digits {tens, ones}, for on-screen 7-segment display.
REQ-017 lives  output  2  remaining lives.
REQ-018 speed  output  2  speed level for ball step size.
REQ-019 state  output  3  current state encoding (debug).

Function
REQ-020 frame_tick SHALL be internal, true for the single cycle with xpos==0 and ypos==480.
REQ-021 go SHALL pass a 2-flop synchronizer plus a third edge flop; go_edge = stage2 & ~stage3.
REQ-022 States SHALL be IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4; encodings 5-7 SHALL go to IDLE next cycle.
REQ-023 All outputs SHALL be registered; a transition triggered in cycle N is visible on outputs in cycle N+1.
REQ-024 IDLE: ball_run=0; on go_edge -> SERVE, score=0x00, lives=LIVES_INIT, speed=0, hit counter=0, ball_reset pulsed.
REQ-025 SERVE: frame counter loaded SERVE_FRAMES-1 on entry; each frame_tick decrements; frame_tick with counter==0 -> PLAY.
REQ-026 PLAY: ball_run=1; hit increments score BCD (ones 9 wraps to 0 with tens carry); score saturates at 0x99.
REQ-027 PLAY: each hit increments hit counter; hit with counter==SPEEDUP_HITS-1 clears counter and increments speed, saturating at 3.
REQ-028 PLAY: miss -> MISS, lives decremented by 1, counter loaded MISS_FRAMES-1, ball_run=0 next cycle.
REQ-029 hit and miss in the same cycle: miss SHALL win; score, hit counter and speed unchanged.
REQ-030 MISS: flash=1, ball_run=0; counter decrements per frame_tick; at frame_tick with counter==0: lives==0 -> OVER, else -> SERVE with ball_reset pulse.
REQ-031 OVER: game_over=1, score/speed held; go_edge -> new game exactly as REQ-024.
REQ-032 hit/miss SHALL be ignored outside PLAY; go_edge SHALL be ignored in SERVE, PLAY, MISS.
REQ-033 ball_reset SHALL be high for exactly one cycle per SERVE entry and never otherwise.
REQ-034 lives SHALL never underflow below 0.

Reset
REQ-035 reset high at a clock edge SHALL force, next cycle: state=IDLE, score=0x00, lives=LIVES_INIT, speed=0, ball_run=0, ball_reset=0, flash=0, game_over=0, counters and synchronizer flops 0.
REQ-036 reset SHALL take priority over every other input, including mid-SERVE/PLAY/MISS.
REQ-037 go held high through reset release SHALL NOT start a game; a new rising edge is required.

Verification
REQ-038 SERVE_FRAMES=2: go rises -> ball_reset pulse within 4 cycles, state=1; ball_run=1 after 2nd frame_tick.
REQ-039 PLAY, SPEEDUP_HITS=5: 12 hit pulses -> score=0x12, speed=2; 99 more hits -> score=0x99 held.
REQ-040 LIVES_INIT=1, MISS_FRAMES=3: miss in PLAY -> flash=1, lives=0; 3rd frame_tick -> game_over=1, state=4.
REQ-041 hit and miss same cycle with score=0x04 -> score stays 0x04, state=MISS, lives decremented.
REQ-042 reset asserted mid-PLAY with score=0x37 -> next cycle state=0, score=0x00, ball_run=0; go held high through release -> stays IDLE.
REQ-043 hit/miss pulses in IDLE, SERVE, OVER -> no change to score, lives, speed or state.
